// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned MODE_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    OWNED    = 2'd2,
    BUSY     = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    MODE_RD  = 2'b00,
    MODE_WR  = 2'b01,
    MODE_RMW = 2'b10,
    MODE_NOP = 2'b11
  } mode_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes
// to the master that did not win last time.
module rr_pick2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       winner_o
);

  always_comb begin
    winner_o = 1'b0;
    unique case (req_i)
      2'b10:   winner_o = 1'b1;
      2'b11:   winner_o = ~last_i;
      default: winner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arb2.sv
// Two-master round-robin arbiter onto a single req/gnt/start/rdy memory slave.
// Define ARB_TIMEOUT_EN to enable the BUSY watchdog (err pulse + abort).
module mem_bus_arb2
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned MODE_W  = MODE_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_start,
  input  logic [ADDR_W-1:0] m_addr0,
  input  logic [ADDR_W-1:0] m_addr1,
  input  logic [MODE_W-1:0] m_mode0,
  input  logic [MODE_W-1:0] m_mode1,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rdy,
  output logic              mem_req,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MODE_W-1:0] mem_mode,
  input  logic              mem_gnt,
  input  logic              mem_rdy,
  output logic              err
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_bus_arb2: TIMEOUT must be at least 1");
  end

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       pick;
  logic       req_sel, start_sel;
  logic       timeout;

  rr_pick2 u_pick (
    .req_i    (m_req),
    .last_i   (last_q),
    .winner_o (pick)
  );

  assign req_sel   = m_req[sel_q];
  assign start_sel = m_start[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Compare against TIMEOUT-1 so the abort lands on the TIMEOUT-th BUSY cycle.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err     = (state_q == BUSY) && timeout && !mem_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == OWNED && start_sel)   cnt_d = '0;
    else if (state_q == BUSY && !mem_rdy) cnt_d = cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|m_req) begin
          sel_d   = pick;
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        // A dropped request beats a simultaneous grant.
        if (!req_sel)     state_d = IDLE;
        else if (mem_gnt) state_d = OWNED;
      end
      OWNED: begin
        if (start_sel)    state_d = BUSY;
        else if (!req_sel) state_d = IDLE;
      end
      BUSY: begin
        if (mem_rdy || timeout) begin
          last_d  = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    m_gnt     = '0;
    m_rdy     = '0;
    mem_req   = (state_q != IDLE);
    mem_start = 1'b0;
    mem_addr  = '0;
    mem_mode  = '0;
    if (state_q == OWNED || state_q == BUSY) begin
      m_gnt[sel_q] = 1'b1;
      mem_addr     = sel_q ? m_addr1 : m_addr0;
      mem_mode     = sel_q ? m_mode1 : m_mode0;
    end
    if (state_q == OWNED) mem_start    = start_sel;
    if (state_q == BUSY)  m_rdy[sel_q] = mem_rdy;
  end

endmodule

// File: tb/tb_mem_bus_arb2.sv
// Directed self-checking bench for mem_bus_arb2 (watchdog steps need ARB_TIMEOUT_EN).
module tb_mem_bus_arb2;
  import mem_bus_pkg::*;

  logic       clk, rst;
  logic [1:0] m_req, m_start, m_gnt, m_rdy;
  logic [7:0] m_addr0, m_addr1, mem_addr;
  logic [1:0] m_mode0, m_mode1, mem_mode;
  logic       mem_req, mem_start, mem_gnt, mem_rdy, err;

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  mem_bus_arb2 #(.ADDR_W(8), .MODE_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_start(m_start),
    .m_addr0(m_addr0), .m_addr1(m_addr1), .m_mode0(m_mode0), .m_mode1(m_mode1),
    .m_gnt(m_gnt), .m_rdy(m_rdy), .mem_req(mem_req), .mem_start(mem_start),
    .mem_addr(mem_addr), .mem_mode(mem_mode), .mem_gnt(mem_gnt),
    .mem_rdy(mem_rdy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fields: gnt, rdy, req, start, addr, mode, err
  task automatic chk(input string tag, input logic [1:0] gnt, input logic [1:0] rdy,
                     input logic req, input logic st, input logic [7:0] a,
                     input logic [1:0] md, input logic e);
    logic [16:0] obs, exp;
    #1;
    obs = {m_gnt, m_rdy, mem_req, mem_start, mem_addr, mem_mode, err};
    exp = {gnt, rdy, req, st, a, md, e};
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %05h required %05h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; m_req = '0; m_start = '0; mem_gnt = 1'b0; mem_rdy = 1'b0;
    tick();
    chk("reset", 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic       e;
    logic [1:0] oh;
    m_addr0 = 8'hA5; m_mode0 = 2'b01;
    m_addr1 = 8'h3C; m_mode1 = 2'b10;
    do_reset();

    // Single master 0 transfer
    m_req = 2'b01;              chk("s_idle", 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0); tick();
                                chk("s_wait1", 2'b00, 2'b00, 1, 0, 8'h00, 2'b00, 0); tick();
                                chk("s_wait2", 2'b00, 2'b00, 1, 0, 8'h00, 2'b00, 0); tick();
    mem_gnt = 1'b1;             chk("s_wait3", 2'b00, 2'b00, 1, 0, 8'h00, 2'b00, 0); tick();
    mem_gnt = 1'b0; m_start = 2'b01;
                                chk("s_owned", 2'b01, 2'b00, 1, 1, 8'hA5, 2'b01, 0); tick();
    m_start = 2'b00;            chk("s_busy1", 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 0); tick();
                                chk("s_busy2", 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 0); tick();
    mem_rdy = 1'b1;             chk("s_rdy", 2'b01, 2'b01, 1, 0, 8'hA5, 2'b01, 0); tick();
    m_req = 2'b00;              chk("s_idle_stray_rdy", 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0); tick();
    mem_rdy = 1'b0;

    // Start from non-owner is ignored
    m_req = 2'b01; tick();
    mem_gnt = 1'b1;             chk("n_wait", 2'b00, 2'b00, 1, 0, 8'h00, 2'b00, 0); tick();
    mem_gnt = 1'b0; m_start = 2'b10;
                                chk("n_owned_foreign", 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 0); tick();
    m_start = 2'b00;            chk("n_still_owned", 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 0); tick();
    m_start = 2'b01;            chk("n_own_start", 2'b01, 2'b00, 1, 1, 8'hA5, 2'b01, 0); tick();
    m_start = 2'b00; mem_rdy = 1'b1;
                                chk("n_rdy", 2'b01, 2'b01, 1, 0, 8'hA5, 2'b01, 0); tick();
    mem_rdy = 1'b0; m_req = 2'b00;

    // Contention: strict alternation 0,1,0,1 from reset
    do_reset();
    m_req = 2'b11; mem_gnt = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      e  = k[0];
      oh = e ? 2'b10 : 2'b01;
      chk($sformatf("c%0d_idle", k), 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0); tick();
      chk($sformatf("c%0d_wait", k), 2'b00, 2'b00, 1, 0, 8'h00, 2'b00, 0); tick();
      m_start = 2'b11;
      chk($sformatf("c%0d_owned", k), oh, 2'b00, 1, 1, e ? 8'h3C : 8'hA5, e ? 2'b10 : 2'b01, 0); tick();
      m_start = 2'b00; mem_rdy = 1'b1;
      chk($sformatf("c%0d_busy", k), oh, oh, 1, 0, e ? 8'h3C : 8'hA5, e ? 2'b10 : 2'b01, 0); tick();
      mem_rdy = 1'b0;
    end
    m_req = 2'b00; mem_gnt = 1'b0;

    // Abandon in WAIT_GNT (drop beats simultaneous grant), last stays 1
    do_reset();
    m_req = 2'b10;              chk("a_idle", 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0); tick();
    m_req = 2'b00; mem_gnt = 1'b1;
                                chk("a_wait_drop", 2'b00, 2'b00, 1, 0, 8'h00, 2'b00, 0); tick();
    mem_gnt = 1'b0; m_req = 2'b11;
                                chk("a_released", 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0); tick();
    mem_gnt = 1'b1;             chk("a_wait2", 2'b00, 2'b00, 1, 0, 8'h00, 2'b00, 0); tick();
    mem_gnt = 1'b0;             chk("a_owned_m0", 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 0);

    // Reset while BUSY discards the transfer
    m_start = 2'b01; tick();
    m_start = 2'b00; rst = 1'b1;
                                chk("r_busy", 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 0); tick();
    rst = 1'b0; m_req = 2'b00; mem_rdy = 1'b1;
                                chk("r_after", 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0); tick();
                                chk("r_idle_rdy", 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0); tick();
    mem_rdy = 1'b0;

`ifdef ARB_TIMEOUT_EN
    for (int unsigned pass_i = 0; pass_i < 2; pass_i++) begin
      do_reset();
      m_req = 2'b01; mem_gnt = 1'b1; tick(); tick();
      m_start = 2'b01; tick();
      m_start = 2'b00; mem_gnt = 1'b0;
      for (int unsigned j = 1; j < 16; j++) begin
        chk($sformatf("t%0d_busy%0d", pass_i, j), 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 0); tick();
      end
      if (pass_i == 0) begin
        chk("t_err", 2'b01, 2'b00, 1, 0, 8'hA5, 2'b01, 1);
      end else begin
        mem_rdy = 1'b1;
        chk("t_rdy_wins", 2'b01, 2'b01, 1, 0, 8'hA5, 2'b01, 0);
      end
      tick();
      mem_rdy = 1'b0;
      m_req = 2'b00;
      chk($sformatf("t%0d_after", pass_i), 2'b00, 2'b00, 0, 0, 8'h00, 2'b00, 0);
    end
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
